operand_debounce_latch: RTL and testbench

//  Input stage directly upstream of the N-bit adder / hex 7-seg display path.

---
 rtl/operand_debounce_latch_if.sv | 23 ++
 rtl/operand_debounce_latch.sv | 130 +++++++++++++
 tb/tb_operand_debounce_latch.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/operand_debounce_latch_if.sv
// Operand/load-key bundle between the board switches and the operand latch.
// master drives the raw inputs and observes the latched operands; slave is the latch.
interface operand_debounce_latch_if #(
    parameter int N = 3
);
    logic [N-1:0] i_sw_a;
    logic [N-1:0] i_sw_b;
    logic         i_key_n;
    logic [N-1:0] o_a;
    logic [N-1:0] o_b;
    logic         o_load;
    logic [7:0]   o_cap_cnt;

    modport master (
        output i_sw_a, i_sw_b, i_key_n,
        input  o_a, o_b, o_load, o_cap_cnt
    );

    modport slave (
        input  i_sw_a, i_sw_b, i_key_n,
        output o_a, o_b, o_load, o_cap_cnt
    );
endinterface

// File: rtl/operand_debounce_latch.sv
// Synchronises and debounces operand switches and the active-low load key, then
// latches both operands once per debounced key press for the adder/display path.

module operand_debounce_latch_db #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RST_VAL         = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic db_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   stable_q, stable_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign db_o   = stable_q;

    // A change is accepted only after it has differed from the stable value for
    // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_s != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) stable_d = sync_s;
            else                                   cnt_d    = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q   <= {SYNC_STAGES{RST_VAL}};
            stable_q <= RST_VAL;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

module operand_debounce_latch #(
    parameter int N               = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    operand_debounce_latch_if.slave        bus
);
    localparam int W = 2 * N + 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, HELD} state_t;

    logic [W-1:0] raw_s, db_s;
    logic [N-1:0] sw_a_db, sw_b_db;
    logic         key_db;

    state_t       state_q, state_d;
    logic [N-1:0] a_q, a_d, b_q, b_d;
    logic         load_q, load_d;
    logic [7:0]   cnt_q, cnt_d;

    assign raw_s = {bus.i_key_n, bus.i_sw_b, bus.i_sw_a};

    // Key bit (MSB) idles released-high; switches idle low.
    for (genvar g = 0; g < W; g++) begin : g_db
        operand_debounce_latch_db #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RST_VAL        ((g == W - 1) ? 1'b1 : 1'b0)
        ) u_db (
            .clk  (i_clk),
            .rst_n(i_rst_n),
            .raw_i(raw_s[g]),
            .db_o (db_s[g])
        );
    end

    assign sw_a_db = db_s[N-1:0];
    assign sw_b_db = db_s[2*N-1:N];
    assign key_db  = db_s[W-1];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        load_d  = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (!key_db) state_d = CAPTURE;
            CAPTURE: begin
                a_d     = sw_a_db;
                b_d     = sw_b_db;
                load_d  = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                state_d = HELD;
            end
            HELD: if (key_db) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            load_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            load_q  <= load_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_a       = a_q;
    assign bus.o_b       = b_q;
    assign bus.o_load    = load_q;
    assign bus.o_cap_cnt = cnt_q;
endmodule

// File: tb/tb_operand_debounce_latch.sv
// Directed bench for operand_debounce_latch with N=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_operand_debounce_latch;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    int   load_cnt = 0;
    int   last_load_edge = -1;

    operand_debounce_latch_if #(.N(3)) bus ();

    operand_debounce_latch #(
        .N(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Every high sample of o_load is counted, so a two-cycle pulse shows as two.
    always @(negedge clk) begin
        if (bus.o_load === 1'b1) begin
            load_cnt       = load_cnt + 1;
            last_load_edge = edge_n;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.i_key_n = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(10);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.i_sw_a  = 3'($urandom);
            bus.i_sw_b  = 3'($urandom);
            bus.i_key_n = 1'($urandom);
            tick(1);
        end
        checks++; if (bus.o_a !== 3'd0) begin errors++; $display("FAIL reset_a got %0d exp 0", bus.o_a); end
        checks++; if (bus.o_b !== 3'd0) begin errors++; $display("FAIL reset_b got %0d exp 0", bus.o_b); end
        checks++; if (bus.o_load !== 1'b0) begin errors++; $display("FAIL reset_load got %b exp 0", bus.o_load); end
        checks++; if (bus.o_cap_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bus.o_cap_cnt); end
        bus.i_sw_a = 3'd0; bus.i_sw_b = 3'd0; bus.i_key_n = 1'b1;
        rst_n = 1'b1;
        tick(10);
        checks++; if (load_cnt !== 0) begin errors++; $display("FAIL reset_no_pulse got %0d exp 0", load_cnt); end
    endtask

    task automatic test_basic();
        int n0, t0;
        logic [3:0] sum;
        bus.i_sw_a = 3'd5; bus.i_sw_b = 3'd3;
        tick(10);
        n0 = load_cnt;
        bus.i_key_n = 1'b0;
        t0 = edge_n;
        tick(20);
        bus.i_key_n = 1'b1;
        tick(10);
        sum = {1'b0, bus.o_a} + {1'b0, bus.o_b};
        checks++; if (load_cnt - n0 !== 1) begin errors++; $display("FAIL basic_pulses got %0d exp 1", load_cnt - n0); end
        checks++; if (last_load_edge !== t0 + 8) begin errors++; $display("FAIL basic_latency got edge %0d exp %0d", last_load_edge, t0 + 8); end
        checks++; if (bus.o_a !== 3'd5) begin errors++; $display("FAIL basic_a got %0d exp 5", bus.o_a); end
        checks++; if (bus.o_b !== 3'd3) begin errors++; $display("FAIL basic_b got %0d exp 3", bus.o_b); end
        checks++; if (bus.o_cap_cnt !== 8'd1) begin errors++; $display("FAIL basic_cnt got %0d exp 1", bus.o_cap_cnt); end
        checks++; if (sum !== 4'd8) begin errors++; $display("FAIL basic_sum got %0d exp 8", sum); end
    endtask

    task automatic test_bounce();
        int n0, t1;
        bus.i_sw_a = 3'd1; bus.i_sw_b = 3'd6;
        tick(10);
        n0 = load_cnt;
        for (int i = 0; i < 8; i++) begin
            bus.i_key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
        end
        checks++; if (load_cnt - n0 !== 0) begin errors++; $display("FAIL bounce_quiet got %0d exp 0", load_cnt - n0); end
        bus.i_key_n = 1'b0;
        t1 = edge_n;
        tick(12);
        checks++; if (load_cnt - n0 !== 1) begin errors++; $display("FAIL bounce_pulses got %0d exp 1", load_cnt - n0); end
        checks++; if (last_load_edge !== t1 + 8) begin errors++; $display("FAIL bounce_latency got edge %0d exp %0d", last_load_edge, t1 + 8); end
        checks++; if (bus.o_a !== 3'd1 || bus.o_b !== 3'd6) begin errors++; $display("FAIL bounce_ops got %0d/%0d exp 1/6", bus.o_a, bus.o_b); end
        checks++; if (bus.o_cap_cnt !== 8'd2) begin errors++; $display("FAIL bounce_cnt got %0d exp 2", bus.o_cap_cnt); end
        bus.i_key_n = 1'b1;
        tick(10);
    endtask

    task automatic test_glitch();
        int n0;
        bus.i_sw_a = 3'd5;
        tick(10);
        n0 = load_cnt;
        bus.i_key_n = 1'b0;
        tick(2);
        bus.i_sw_a = 3'd2;
        tick(3);
        bus.i_sw_a = 3'd5;
        tick(10);
        checks++; if (load_cnt - n0 !== 1) begin errors++; $display("FAIL glitch_pulses got %0d exp 1", load_cnt - n0); end
        checks++; if (bus.o_a !== 3'd5) begin errors++; $display("FAIL glitch_a got %0d exp 5", bus.o_a); end
        checks++; if (bus.o_b !== 3'd6) begin errors++; $display("FAIL glitch_b got %0d exp 6", bus.o_b); end
        checks++; if (bus.o_cap_cnt !== 8'd3) begin errors++; $display("FAIL glitch_cnt got %0d exp 3", bus.o_cap_cnt); end
        bus.i_key_n = 1'b1;
        tick(10);
    endtask

    task automatic test_back_to_back();
        int n0;
        do_reset();
        bus.i_sw_a = 3'd3; bus.i_sw_b = 3'd4;
        tick(10);
        n0 = load_cnt;
        bus.i_key_n = 1'b0;
        tick(100);
        checks++; if (load_cnt - n0 !== 1) begin errors++; $display("FAIL hold_pulses got %0d exp 1", load_cnt - n0); end
        checks++; if (bus.o_cap_cnt !== 8'd1) begin errors++; $display("FAIL hold_cnt got %0d exp 1", bus.o_cap_cnt); end
        bus.i_key_n = 1'b1;
        tick(10);
        bus.i_key_n = 1'b0;
        tick(12);
        checks++; if (load_cnt - n0 !== 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", load_cnt - n0); end
        checks++; if (bus.o_cap_cnt !== 8'd2) begin errors++; $display("FAIL b2b_cnt got %0d exp 2", bus.o_cap_cnt); end
        bus.i_key_n = 1'b1;
        tick(10);
        bus.i_sw_a = 3'd7; bus.i_sw_b = 3'd7;
        tick(20);
        checks++; if (bus.o_a !== 3'd3 || bus.o_b !== 3'd4) begin errors++; $display("FAIL nopress_ops got %0d/%0d exp 3/4", bus.o_a, bus.o_b); end
        checks++; if (load_cnt - n0 !== 2) begin errors++; $display("FAIL nopress_pulses got %0d exp 2", load_cnt - n0); end
    endtask

    task automatic test_wrap_and_reset();
        int n0, t;
        do_reset();
        bus.i_sw_a = 3'd2; bus.i_sw_b = 3'd1;
        tick(10);
        n0 = load_cnt;
        for (int i = 0; i < 256; i++) begin
            bus.i_key_n = 1'b0;
            tick(10);
            bus.i_key_n = 1'b1;
            tick(10);
            if (i == 254) begin
                checks++; if (bus.o_cap_cnt !== 8'd255) begin errors++; $display("FAIL cnt_255 got %0d exp 255", bus.o_cap_cnt); end
            end
        end
        checks++; if (bus.o_cap_cnt !== 8'd0) begin errors++; $display("FAIL cnt_wrap got %0d exp 0", bus.o_cap_cnt); end
        checks++; if (load_cnt - n0 !== 256) begin errors++; $display("FAIL wrap_pulses got %0d exp 256", load_cnt - n0); end
        bus.i_key_n = 1'b0;
        tick(10);
        checks++; if (bus.o_cap_cnt !== 8'd1 || bus.o_a !== 3'd2) begin errors++; $display("FAIL prereset_cap got cnt %0d a %0d exp 1/2", bus.o_cap_cnt, bus.o_a); end
        rst_n = 1'b0;
        tick(3);
        checks++; if (bus.o_a !== 3'd0 || bus.o_b !== 3'd0) begin errors++; $display("FAIL midreset_ops got %0d/%0d exp 0/0", bus.o_a, bus.o_b); end
        checks++; if (bus.o_cap_cnt !== 8'd0 || bus.o_load !== 1'b0) begin errors++; $display("FAIL midreset_cnt got %0d load %b exp 0/0", bus.o_cap_cnt, bus.o_load); end
        rst_n = 1'b1;
        t = edge_n;
        n0 = load_cnt;
        tick(12);
        checks++; if (load_cnt - n0 !== 1) begin errors++; $display("FAIL postreset_pulses got %0d exp 1", load_cnt - n0); end
        checks++; if (last_load_edge !== t + 8) begin errors++; $display("FAIL postreset_latency got edge %0d exp %0d", last_load_edge, t + 8); end
        checks++; if (bus.o_cap_cnt !== 8'd1 || bus.o_a !== 3'd2 || bus.o_b !== 3'd1) begin errors++; $display("FAIL postreset_state got cnt %0d a %0d b %0d exp 1/2/1", bus.o_cap_cnt, bus.o_a, bus.o_b); end
        bus.i_key_n = 1'b1;
        tick(10);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_sw_a = 3'd0; bus.i_sw_b = 3'd0; bus.i_key_n = 1'b1;
        test_reset();
        test_basic();
        test_bounce();
        test_glitch();
        test_back_to_back();
        test_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
